sim_halt_monitor: RTL and testbench
===================================

// Module: sim_halt_monitor
// PURPOSE
//  Watches the core's data-memory write port downstream of top and decides when a simulation run ends.
//  Detects a halt write to the TOHOST address and captures the exit code.
//  Counts cycles and writes; the bench polls done/pass to drive $finish instead of a fixed delay.
//  Synthesizable, so it can also drive a board status LED.
// PARAMETERS
//  TOHOST_ADDR     32'h0000_1000  word address whose write (data[0]=1) signals halt
//  DRAIN_CYCLES    4              cycles held in DRAIN after halt before done asserts (1..15)
//  TIMEOUT_CYCLES  32'd100000     watchdog limit in cycles (used only with SIM_HALT_TIMEOUT_EN)
// PORTS
//  clk          in   1   core clock
//  reset_n      in   1   asynchronous, active-low reset
//  mem_we       in   1   data-memory write strobe from core, one write per cycle max
//  mem_addr     in   32  write address, valid when mem_we=1
//  mem_data     in   32  write data, valid when mem_we=1
//  done         out  1   run finished (halt or timeout), sticky until reset
//  pass         out  1   valid when done: 1 = halt with exit code 0
//  timeout      out  1   valid when done: 1 = watchdog expired
//  exit_code    out  31  mem_data[31:1] of the halt write; all ones on timeout
//  cycle_count  out  32  cycles spent in RUN, saturating at 32'hFFFF_FFFF
//  write_count  out  32  mem_we pulses accepted in RUN, saturating
// BEHAVIOUR
//  - Interface: one clock, clk; reset_n is asynchronous and active-low.
//    Assertion clears all state immediately, without waiting for a clock edge.
//  - Reset values: state=RUN; done, pass and timeout are 0; exit_code, cycle_count, write_count and the drain counter are 0.
//  - FSM RUN -> DRAIN -> DONE. DONE is terminal until reset.
//    RUN: cycle_count increments every cycle. write_count increments on mem_we.
//    Halt = mem_we && mem_addr==TOHOST_ADDR && mem_data[0]==1. It counts as a write.
//    On halt: exit_code<=mem_data[31:1], drain counter<=DRAIN_CYCLES-1, next state DRAIN.
//    A write to TOHOST with data[0]=0 is an ordinary write, not a halt.
//    DRAIN: counters frozen; further writes, including a second halt, are ignored.
//    When the drain counter reaches 0: done<=1, pass<=(exit_code==0), state DONE.
//    done therefore rises exactly DRAIN_CYCLES clocks after the halt-write edge.
//    DONE: all outputs hold and inputs are ignored.
//  - Saturation: at all ones, a counter stops rather than wrapping.
//  - Simultaneous halt and watchdog limit in the same RUN cycle: halt wins and timeout stays 0.
//  - Reset mid-DRAIN or in DONE returns to RUN with counters cleared.
//    A halt presented on the first clock after reset release is accepted.
// CONFIGURATION
//  SIM_HALT_TIMEOUT_EN defined:
//    In RUN, when cycle_count==TIMEOUT_CYCLES-1 and there is no halt, go straight to DONE
//    with done=1, timeout=1, pass=0, exit_code=31'h7FFF_FFFF. DRAIN is skipped.
//  SIM_HALT_TIMEOUT_EN undefined:
//    No watchdog logic; timeout is tied to 0 and TIMEOUT_CYCLES is unused.
// STRUCTURE
//  wizard_sim_pkg holds:
//    typedef enum logic [1:0] {HM_RUN, HM_DRAIN, HM_DONE} halt_state_t
//    localparam TOHOST_ADDR_DEFAULT = 32'h0000_1000
//    localparam EXIT_TIMEOUT = 31'h7FFF_FFFF
//  sat_counter #(WIDTH) is one sub-module (inc, clr, q), instantiated for cycle_count and write_count.
//  FSM and capture registers are in this module.
// TESTING
//  1. Reset, 10 idle cycles, write 32'h1 to 32'h1000
//     -> done=1 exactly 4 clocks later, pass=1, exit_code=0, cycle_count=11, write_count=1.
//  2. Write 32'h0000_0007 to TOHOST
//     -> done=1, pass=0, exit_code=3.
//     Then write 32'h1 to TOHOST during DRAIN -> exit_code stays 3, write_count unchanged.
//  3. Write 32'h2 to TOHOST (bit0=0), then 5 writes elsewhere
//     -> no halt, write_count=6, done=0.
//  4. Assert reset_n=0 mid-DRAIN, between clock edges
//     -> done, counters and exit_code clear immediately. Release, halt again -> normal completion.
//  5. SIM_HALT_TIMEOUT_EN, TIMEOUT_CYCLES=50, no halt
//     -> after cycle 50: done=1, timeout=1, pass=0, exit_code=31'h7FFF_FFFF.
//     With halt exactly at cycle 50 -> timeout=0.
//  6. Force write_count to 32'hFFFF_FFFE, issue 3 writes
//     -> write_count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/wizard_sim_pkg.sv
// Shared types and constants for the simulation halt monitor.
package wizard_sim_pkg;

  typedef enum logic [1:0] {HM_RUN, HM_DRAIN, HM_DONE} halt_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [30:0] EXIT_TIMEOUT        = 31'h7FFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts on inc, clears synchronously on clr,
// and sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next count: clear has priority, increment only below all ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sim_halt_monitor.sv
// Simulation halt monitor: watches data-memory writes for a halt write to
// TOHOST, captures the exit code, drains a few cycles, then raises a sticky
// done/pass. Counts RUN cycles and accepted writes.
// Optional watchdog: define SIM_HALT_TIMEOUT_EN to end the run with
// timeout=1 when no halt arrives within TIMEOUT_CYCLES.
module sim_halt_monitor
  import wizard_sim_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code,
  output logic [31:0] cycle_count,
  output logic [31:0] write_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  halt_state_t state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [30:0] exit_q, exit_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic        in_run;
  logic        halt;
  logic        wd_hit;

  assign in_run = (state_q == HM_RUN);
  assign halt   = mem_we && (mem_addr == TOHOST_ADDR) && mem_data[0];

`ifdef SIM_HALT_TIMEOUT_EN
  assign wd_hit  = (cycle_count == (TIMEOUT_CYCLES - 32'd1));
  assign timeout = tmo_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Counters run only while in RUN, which freezes them during DRAIN and DONE.
  sat_counter #(.WIDTH(32)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (in_run),
    .clr   (1'b0),
    .q     (cycle_count)
  );

  sat_counter #(.WIDTH(32)) u_write_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (in_run && mem_we),
    .clr   (1'b0),
    .q     (write_count)
  );

  // Next-state logic; halt takes priority over the watchdog in RUN.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    exit_d  = exit_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      HM_RUN: begin
        if (halt) begin
          exit_d  = mem_data[31:1];
          drain_d = DRAIN_LOAD;
          state_d = HM_DRAIN;
        end else if (wd_hit) begin
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          exit_d  = EXIT_TIMEOUT;
          state_d = HM_DONE;
        end
      end
      HM_DRAIN: begin
        if (drain_q == 4'd0) begin
          done_d  = 1'b1;
          pass_d  = (exit_q == 31'd0);
          state_d = HM_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      HM_DONE: begin
      end
      default: state_d = HM_RUN;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HM_RUN;
      drain_q <= 4'd0;
      exit_q  <= 31'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      exit_q  <= exit_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign exit_code = exit_q;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Self-checking bench for sim_halt_monitor with an expected-completion queue.
module tb_sim_halt_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        done, pass, timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_count, write_count;

  logic       sat_inc = 1'b0;
  logic       sat_clr = 1'b0;
  logic [2:0] sat_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        e_pass;
    logic        e_tmo;
    logic [30:0] e_code;
    logic [31:0] e_cyc;
    logic [31:0] e_wr;
    int          e_lat;
  } exp_t;

  exp_t sb[$];

  sim_halt_monitor #(
    .TOHOST_ADDR    (32'h0000_1000),
    .DRAIN_CYCLES   (4),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .cycle_count (cycle_count),
    .write_count (write_count)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (sat_inc),
    .clr   (sat_clr),
    .q     (sat_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    mem_we  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; presents one write for the next posedge.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
    mem_we   = 1'b1;
    mem_addr = a;
    mem_data = d;
    @(negedge clk);
    mem_we   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output bit ok);
    lat = 0;
    while (!done && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({done, pass, timeout, exit_code, cycle_count, write_count} !== '0) begin
      failures++;
      $display("FAIL reset_values got done=%0b pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d required all zero",
               done, pass, timeout, exit_code, cycle_count, write_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cycle_count !== 32'd3 || write_count !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_count got cyc=%0d wr=%0d done=%0b required cyc=3 wr=0 done=0",
               cycle_count, write_count, done);
    end
  endtask

  task automatic test_halt_pass();
    exp_t e;
    int   lat;
    bit   ok;
    apply_reset();
    repeat (10) @(negedge clk);
    sb.push_back('{e_pass:1'b1, e_tmo:1'b0, e_code:31'd0, e_cyc:32'd11, e_wr:32'd1, e_lat:4});
    drive_write(32'h0000_1000, 32'h0000_0001);
    wait_done(100, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat) begin
      failures++;
      $display("FAIL halt_pass_latency got done=%0b after %0d clocks required %0d", ok, lat, e.e_lat);
    end
    checks++;
    if ({pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL halt_pass_result got pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d required pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d",
               pass, timeout, exit_code, cycle_count, write_count, e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr);
    end
    drive_write(32'h0000_1000, 32'h0000_000F);
    drive_write(32'h0000_3000, 32'h0000_0001);
    repeat (2) @(negedge clk);
    checks++;
    if ({done, pass, timeout, exit_code, cycle_count, write_count} !== {1'b1, e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL done_hold got done=%0b pass=%0b code=%0h cyc=%0d wr=%0d required done=1 pass=%0b code=%0h cyc=%0d wr=%0d",
               done, pass, exit_code, cycle_count, write_count, e.e_pass, e.e_code, e.e_cyc, e.e_wr);
    end
  endtask

  task automatic test_halt_fail_drain();
    exp_t e;
    int   lat;
    bit   ok;
    apply_reset();
    sb.push_back('{e_pass:1'b0, e_tmo:1'b0, e_code:31'd3, e_cyc:32'd1, e_wr:32'd1, e_lat:4});
    drive_write(32'h0000_1000, 32'h0000_0007);
    drive_write(32'h0000_1000, 32'h0000_0001);
    drive_write(32'h0000_2000, 32'h0000_0005);
    wait_done(100, lat, ok);
    lat = lat + 2;
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat) begin
      failures++;
      $display("FAIL halt_fail_latency got done=%0b after %0d clocks required %0d", ok, lat, e.e_lat);
    end
    checks++;
    if ({pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL halt_fail_result got pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d required pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d",
               pass, timeout, exit_code, cycle_count, write_count, e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   ok;
    apply_reset();
    drive_write(32'h0000_1000, 32'h0000_0002);
    for (int i = 0; i < 5; i++) begin
      drive_write(32'h0000_2000 + 32'(i * 4), 32'(i));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || write_count !== 32'd6 || cycle_count !== 32'd8) begin
      failures++;
      $display("FAIL nonhalt_writes got done=%0b wr=%0d cyc=%0d required done=0 wr=6 cyc=8",
               done, write_count, cycle_count);
    end
    sb.push_back('{e_pass:1'b1, e_tmo:1'b0, e_code:31'd0, e_cyc:32'd9, e_wr:32'd7, e_lat:4});
    drive_write(32'h0000_1000, 32'h0000_0001);
    wait_done(100, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat ||
        {pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL b2b_halt got done=%0b lat=%0d pass=%0b code=%0h cyc=%0d wr=%0d required lat=%0d pass=%0b code=%0h cyc=%0d wr=%0d",
               ok, lat, pass, exit_code, cycle_count, write_count, e.e_lat, e.e_pass, e.e_code, e.e_cyc, e.e_wr);
    end
  endtask

  task automatic test_reset_mid_drain();
    exp_t e;
    int   lat;
    bit   ok;
    apply_reset();
    drive_write(32'h0000_1000, 32'h0000_000B);
    @(negedge clk);
    #2;
    checks++;
    if (exit_code !== 31'd5 || done !== 1'b0) begin
      failures++;
      $display("FAIL drain_capture got code=%0h done=%0b required code=5 done=0", exit_code, done);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({done, pass, timeout, exit_code, cycle_count, write_count} !== '0) begin
      failures++;
      $display("FAIL async_reset_clear got done=%0b code=%0h cyc=%0d wr=%0d required all zero",
               done, exit_code, cycle_count, write_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back('{e_pass:1'b1, e_tmo:1'b0, e_code:31'd0, e_cyc:32'd1, e_wr:32'd1, e_lat:4});
    drive_write(32'h0000_1000, 32'h0000_0001);
    wait_done(100, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat ||
        {pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL first_clock_halt got done=%0b lat=%0d pass=%0b code=%0h cyc=%0d wr=%0d required lat=%0d pass=1 code=0 cyc=1 wr=1",
               ok, lat, pass, exit_code, cycle_count, write_count, e.e_lat);
    end
  endtask

  task automatic test_watchdog();
    exp_t e;
    int   lat;
    bit   ok;
    apply_reset();
`ifdef SIM_HALT_TIMEOUT_EN
    sb.push_back('{e_pass:1'b0, e_tmo:1'b1, e_code:31'h7FFF_FFFF, e_cyc:32'd50, e_wr:32'd0, e_lat:50});
    wait_done(60, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat ||
        {pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL watchdog_expire got done=%0b lat=%0d pass=%0b tmo=%0b code=%0h cyc=%0d required lat=50 pass=0 tmo=1 code=7fffffff cyc=50",
               ok, lat, pass, timeout, exit_code, cycle_count);
    end
`else
    repeat (60) @(negedge clk);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 32'd60) begin
      failures++;
      $display("FAIL no_watchdog got done=%0b tmo=%0b cyc=%0d required done=0 tmo=0 cyc=60",
               done, timeout, cycle_count);
    end
`endif
    apply_reset();
    repeat (49) @(negedge clk);
    sb.push_back('{e_pass:1'b1, e_tmo:1'b0, e_code:31'd0, e_cyc:32'd50, e_wr:32'd1, e_lat:4});
    drive_write(32'h0000_1000, 32'h0000_0001);
    wait_done(100, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.e_lat ||
        {pass, timeout, exit_code, cycle_count, write_count} !== {e.e_pass, e.e_tmo, e.e_code, e.e_cyc, e.e_wr}) begin
      failures++;
      $display("FAIL halt_beats_watchdog got done=%0b lat=%0d pass=%0b tmo=%0b code=%0h cyc=%0d wr=%0d required lat=4 pass=1 tmo=0 code=0 cyc=50 wr=1",
               ok, lat, pass, timeout, exit_code, cycle_count, write_count);
    end
  endtask

  task automatic test_saturation();
    int exp_q;
    apply_reset();
    exp_q = 0;
    checks++;
    if (sat_q !== 3'(exp_q)) begin
      failures++;
      $display("FAIL sat_reset got %0d required %0d", sat_q, exp_q);
    end
    sat_inc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (exp_q < 7) exp_q++;
      if (i == 5 || i == 8) begin
        checks++;
        if (sat_q !== 3'(exp_q)) begin
          failures++;
          $display("FAIL sat_count_%0d got %0d required %0d", i + 1, sat_q, exp_q);
        end
      end
    end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    sat_inc = 1'b0;
    checks++;
    if (sat_q !== 3'd0) begin
      failures++;
      $display("FAIL sat_clear got %0d required 0", sat_q);
    end
  endtask

  initial begin
    test_reset();
    test_halt_pass();
    test_halt_fail_drain();
    test_back_to_back();
    test_reset_mid_drain();
    test_watchdog();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
